// File: rtl/iterative_fpd.sv
// rtl/iterative_fpd.sv - sequential single-precision FP divider, restoring one quotient bit per cycle
module iterative_fpd #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         overflow,
    output logic         underflow,
    output logic         div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [4:0] LAST_ITER = 5'd24;

    state_t      state_q;
    state_t      state_d;

    logic        sign_q;
    logic        a_zero_q;
    logic        b_zero_q;
    logic [7:0]  ea_q;
    logic [7:0]  eb_q;
    logic [23:0] mb_q;
    logic [24:0] rem_q;
    logic [24:0] quo_q;
    logic [4:0]  cnt_q;

    logic        rem_ge;
    logic [24:0] rem_sub;
    logic [24:0] rem_next;
    logic [9:0]  er;
    logic [22:0] mr;
    logic        er_high;
    logic        er_low;

    // State register; reset discards any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = DIV;
                end
            end
            DIV: begin
                if (cnt_q == LAST_ITER) begin
                    state_d = NORM;
                end
            end
            NORM: begin
                state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // One restoring step: compare, conditionally subtract, shift left.
    always_comb begin
        rem_ge   = (rem_q >= {1'b0, mb_q});
        rem_sub  = rem_ge ? (rem_q - {1'b0, mb_q}) : rem_q;
        rem_next = {rem_sub[23:0], 1'b0};
    end

    // Normalisation: q[24] set means the quotient is in [1,2), else in [0.5,1).
    always_comb begin
        er      = {2'b00, ea_q} - {2'b00, eb_q} + (quo_q[24] ? 10'd127 : 10'd126);
        mr      = quo_q[24] ? quo_q[23:1] : quo_q[22:0];
        er_high = ($signed(er) > $signed(10'sd254));
        er_low  = ($signed(er) < $signed(10'sd1));
    end

    // Operand capture, iteration and result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sign_q      <= 1'b0;
            a_zero_q    <= 1'b0;
            b_zero_q    <= 1'b0;
            ea_q        <= 8'd0;
            eb_q        <= 8'd0;
            mb_q        <= 24'd0;
            rem_q       <= 25'd0;
            quo_q       <= 25'd0;
            cnt_q       <= 5'd0;
            result      <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sign_q   <= A[31] ^ B[31];
                        // A zero exponent covers true zero and flushed denormals alike.
                        a_zero_q <= (A[30:23] == 8'd0);
                        b_zero_q <= (B[30:23] == 8'd0);
                        ea_q     <= A[30:23];
                        eb_q     <= B[30:23];
                        mb_q     <= {1'b1, B[22:0]};
                        rem_q    <= {2'b01, A[22:0]};
                        quo_q    <= 25'd0;
                        cnt_q    <= 5'd0;
                    end
                end
                DIV: begin
                    rem_q <= rem_next;
                    quo_q <= {quo_q[23:0], rem_ge};
                    cnt_q <= cnt_q + 5'd1;
                end
                NORM: begin
                    overflow    <= 1'b0;
                    underflow   <= 1'b0;
                    div_by_zero <= 1'b0;
                    if (b_zero_q) begin
                        result      <= {sign_q, 8'hFF, 23'd0};
                        div_by_zero <= 1'b1;
                    end else if (a_zero_q) begin
                        result <= '0;
                    end else if (er_high) begin
                        result   <= {sign_q, 8'hFF, 23'd0};
                        overflow <= 1'b1;
                    end else if (er_low) begin
                        result    <= '0;
                        underflow <= 1'b1;
                    end else begin
                        result <= {sign_q, er[7:0], mr};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iterative_fpd.sv
// tb/tb_iterative_fpd.sv - directed self-checking bench for iterative_fpd
module tb_iterative_fpd;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;
    logic        div_by_zero;

    int checks;
    int errors;

    iterative_fpd #(.N(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A          (a_in),
        .B          (b_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .overflow   (overflow),
        .underflow  (underflow),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offers one operand pair, counts edges from the accepting edge (counted as 1)
    // until out_valid is seen, and notes any in_ready while busy.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output int lat, output bit busy_ready);
        int w;
        busy_ready = 1'b0;
        lat = 0;
        @(negedge clk);
        a_in = a;
        b_in = b;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            if (in_ready) busy_ready = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a_in = 32'd0;
        b_in = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
        checks++;
        if ({result, overflow, underflow, div_by_zero} !== 35'd0) begin
            errors++;
            $display("FAIL reset_outputs result=%h flags=%b%b%b required 0", result, overflow, underflow, div_by_zero);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_basic(input string name, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp_res);
        int lat;
        bit busy;
        out_ready = 1'b1;
        run_op(a, b, lat, busy);
        checks++;
        if (lat !== 27) begin
            errors++;
            $display("FAIL %s_latency got %0d required 27", name, lat);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_in_ready_busy got 1 required 0", name);
        end
        checks++;
        if (result !== exp_res || {overflow, underflow, div_by_zero} !== 3'b000) begin
            errors++;
            $display("FAIL %s_result got %h flags %b%b%b required %h 000", name, result,
                     overflow, underflow, div_by_zero, exp_res);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_handshake out_valid=%b in_ready=%b required 0 1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_special(input string name, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] exp_res, input logic [2:0] exp_flags);
        int lat;
        bit busy;
        out_ready = 1'b1;
        run_op(a, b, lat, busy);
        checks++;
        if (lat !== 27) begin
            errors++;
            $display("FAIL %s_latency got %0d required 27", name, lat);
        end
        checks++;
        if (result !== exp_res || {overflow, underflow, div_by_zero} !== exp_flags) begin
            errors++;
            $display("FAIL %s got %h ovf/unf/dbz %b%b%b required %h %b", name, result,
                     overflow, underflow, div_by_zero, exp_res, exp_flags);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure_back_to_back();
        int lat;
        bit busy;
        bit unstable;
        bit ready_seen;
        out_ready = 1'b0;
        run_op(32'h40C00000, 32'h40000000, lat, busy);
        checks++;
        if (lat !== 27 || result !== 32'h40400000) begin
            errors++;
            $display("FAIL bp_first lat=%0d result=%h required 27 40400000", lat, result);
        end
        unstable = 1'b0;
        ready_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = i[0];
            a_in = 32'h3F800000;
            b_in = 32'h40400000;
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || result !== 32'h40400000) unstable = 1'b1;
            if (in_ready !== 1'b0) ready_seen = 1'b1;
        end
        checks++;
        if (unstable) begin
            errors++;
            $display("FAIL bp_hold out_valid=%b result=%h required 1 40400000", out_valid, result);
        end
        checks++;
        if (ready_seen) begin
            errors++;
            $display("FAIL bp_in_ready got 1 during DONE required 0");
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h40400000) begin
            errors++;
            $display("FAIL bp_release out_valid=%b in_ready=%b result=%h required 0 1 40400000",
                     out_valid, in_ready, result);
        end
        run_op(32'hC1000000, 32'h3F000000, lat, busy);
        checks++;
        if (lat !== 27 || result !== 32'hC1800000) begin
            errors++;
            $display("FAIL back_to_back lat=%0d result=%h required 27 c1800000", lat, result);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_op();
        int lat;
        bit busy;
        out_ready = 1'b1;
        @(negedge clk);
        a_in = 32'h3F800000;
        b_in = 32'h40400000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset in_ready=%b out_valid=%b result=%h required 1 0 0",
                     in_ready, out_valid, result);
        end
        @(negedge clk);
        reset = 1'b1;
        run_op(32'h40C00000, 32'h40000000, lat, busy);
        checks++;
        if (lat !== 27 || result !== 32'h40400000 || {overflow, underflow, div_by_zero} !== 3'b000) begin
            errors++;
            $display("FAIL after_reset lat=%0d result=%h required 27 40400000", lat, result);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic("six_by_two", 32'h40C00000, 32'h40000000, 32'h40400000);
        test_basic("one_by_three", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA);
        test_basic("neg_eight_by_half", 32'hC1000000, 32'h3F000000, 32'hC1800000);
        test_special("div_zero", 32'h3F800000, 32'h00000000, 32'h7F800000, 3'b001);
        test_special("zero_by_zero", 32'h00000000, 32'h80000000, 32'hFF800000, 3'b001);
        test_special("neg_zero_dividend", 32'h80000000, 32'h40000000, 32'h00000000, 3'b000);
        test_special("overflow", 32'h7F000000, 32'h00800000, 32'h7F800000, 3'b100);
        test_special("underflow", 32'h00800000, 32'h7F000000, 32'h00000000, 3'b010);
        test_special("denormal_divisor", 32'h3F800000, 32'h00400000, 32'h7F800000, 3'b001);
        test_backpressure_back_to_back();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

endmodule
